demux1_4_32bit_reg: RTL and testbench

- Registered 1-to-4 demultiplexer for the Alu32 datapath. It is the inverse of the 4-to-1 32-bit operand/result selector.
- It accepts one 32-bit word per cycle on a valid/ready input and routes it to one of four output channels chosen by a 2-bit select.
- Each output channel has its own one-entry holding register and a valid/ready handshake.
- It sits between the ALU result bus and four downstream consumers: register-file write, flags unit, memory address, debug tap.

---
 rtl/demux1_4_32bit_reg.sv | 147 ++++++++++++++
 tb/tb_demux1_4_32bit_reg.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1_4_32bit_reg.sv
// demux1_4_32bit_reg: registered 1-to-4 demultiplexer for the Alu32 datapath.
// One word per cycle comes in on a valid/ready port and goes to one of four
// output channels chosen by in_sel. Each channel has a one-entry holding
// register with its own valid/ready handshake, so a stalled consumer only
// blocks words that are addressed to it.
// Optional build macro DEMUX1_4_STATS_EN adds per-channel 16-bit transfer
// counters (stat_count) and a synchronous clear input (stat_clr).
module demux1_4_32bit_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3
`ifdef DEMUX1_4_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [63:0]      stat_count
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e        state_q [4];
  ch_state_e        state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [WIDTH-1:0] data_d  [4];
  logic             accept_s;

  // Ready depends only on the addressed channel: it has room if it is empty
  // or if its consumer drains it in this same cycle.
  always_comb begin
    in_ready = 1'b0;
    if ((state_q[in_sel] == EMPTY) || out_ready[in_sel]) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
  end

  assign accept_s = in_valid & in_ready;

  // Per-channel next state and next data: a new word for this channel wins
  // over a drain, which keeps a full channel streaming at one word per cycle.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      case (state_q[k])
        EMPTY: begin
          if (accept_s && (in_sel == k[1:0])) begin
            state_d[k] = FULL;
            data_d[k]  = in_data;
          end else begin
            state_d[k] = EMPTY;
          end
        end
        FULL: begin
          if (accept_s && (in_sel == k[1:0])) begin
            state_d[k] = FULL;
            data_d[k]  = in_data;
          end else if (out_ready[k]) begin
            state_d[k] = EMPTY;
          end else begin
            state_d[k] = FULL;
          end
        end
        default: begin
          state_d[k] = EMPTY;
        end
      endcase
    end
  end

  // Channel state and holding registers; reset drops every held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= EMPTY;
        data_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
      end
    end
  end

  // Outputs come straight from the registers.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      out_valid[k] = (state_q[k] == FULL);
    end
  end

  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];

`ifdef DEMUX1_4_STATS_EN
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];

  // Count completed output transfers per channel; clear has priority and the
  // counters wrap naturally at 16 bits.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if (stat_clr) begin
        cnt_d[k] = 16'h0000;
      end else if (out_valid[k] && out_ready[k]) begin
        cnt_d[k] = cnt_q[k] + 16'h0001;
      end else begin
        cnt_d[k] = cnt_q[k];
      end
    end
  end

  // Transfer counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= 16'h0000;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign stat_count = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_demux1_4_32bit_reg.sv
// Self-checking bench for demux1_4_32bit_reg. Directed scenario tasks do
// inline checks; a per-channel scoreboard records every accepted word and
// checks each completed output transfer against it in order.
module tb_demux1_4_32bit_reg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data0;
  logic [31:0] out_data1;
  logic [31:0] out_data2;
  logic [31:0] out_data3;
`ifdef DEMUX1_4_STATS_EN
  logic        stat_clr;
  logic [63:0] stat_count;
`endif

  int n_checks;
  int n_pass;
  logic [31:0] sb_q [4][$];

  demux1_4_32bit_reg #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3)
`ifdef DEMUX1_4_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_count(stat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] chan_data(input int k);
    case (k)
      0:       chan_data = out_data0;
      1:       chan_data = out_data1;
      2:       chan_data = out_data2;
      default: chan_data = out_data3;
    endcase
  endfunction

  // Scoreboard: on the falling edge, a channel with valid&ready completes a
  // transfer at the next rising edge; its word must match the oldest entry.
  // Then any word accepted at that edge is recorded for its channel.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          n_checks++;
          if (sb_q[k].size() == 0) begin
            $display("FAIL sb_unexpected ch%0d: got word %h, expected no word", k, chan_data(k));
          end else begin
            logic [31:0] exp_w;
            exp_w = sb_q[k].pop_front();
            if (chan_data(k) !== exp_w)
              $display("FAIL sb_data ch%0d: got %h, expected %h", k, chan_data(k), exp_w);
            else
              n_pass++;
          end
        end
      end
      if (in_valid && in_ready) begin
        sb_q[in_sel].push_back(in_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", name, got, exp);
    else n_pass++;
  endtask

  task automatic clear_sb();
    for (int k = 0; k < 4; k++) sb_q[k].delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_sel = 2'd0; out_ready = 4'b0000;
`ifdef DEMUX1_4_STATS_EN
    stat_clr = 1'b0;
`endif
    #12;
    chk("reset_out_valid", {28'h0, out_valid}, 32'h0);
    chk("reset_data0", out_data0, 32'h0);
    chk("reset_data3", out_data3, 32'h0);
    chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEADBEEF; out_ready = 4'b0000;
    #1;
    chk("basic_in_ready", {31'h0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    #1;
    chk("basic_out_valid", {28'h0, out_valid}, 32'h4);
    chk("basic_data2", out_data2, 32'hDEADBEEF);
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'h12345678; out_ready = 4'b0000;
    #1;
    chk("stall_in_ready_low", {31'h0, in_ready}, 32'h0);
    step();
    chk("stall_data2_held", out_data2, 32'hDEADBEEF);
    out_ready = 4'b0100;
    #1;
    chk("stall_in_ready_high", {31'h0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0; out_ready = 4'b0000;
    #1;
    chk("stall_data2_new", out_data2, 32'h12345678);
    chk("stall_valid2", {31'h0, out_valid[2]}, 32'h1);
  endtask

  task automatic test_independence();
    int chans [3];
    chans = '{0, 1, 3};
    out_ready = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sel = chans[i][1:0]; in_data = 32'(i + 1);
      #1;
      chk($sformatf("indep_in_ready_%0d", i), {31'h0, in_ready}, 32'h1);
      step();
      chk($sformatf("indep_valid_ch%0d", chans[i]), {31'h0, out_valid[chans[i]]}, 32'h1);
      chk($sformatf("indep_data_ch%0d", chans[i]), chan_data(chans[i]), 32'(i + 1));
      chk($sformatf("indep_hold2_%0d", i), {31'h0, out_valid[2]}, 32'h1);
    end
    in_valid = 1'b0;
    step();
    chk("indep_only_ch2", {28'h0, out_valid}, 32'h4);
    chk("indep_data2_kept", out_data2, 32'h12345678);
  endtask

  task automatic test_stream();
    out_ready = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sel = 2'd1; in_data = 32'(i);
      #1;
      chk($sformatf("stream_ready_%0d", i), {31'h0, in_ready}, 32'h1);
      step();
      chk($sformatf("stream_data_%0d", i), out_data1, 32'(i));
      chk($sformatf("stream_valid_%0d", i), {31'h0, out_valid[1]}, 32'h1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", {31'h0, out_valid[1]}, 32'h0);
    out_ready = 4'b0100;
    step();
    chk("stream_all_empty", {28'h0, out_valid}, 32'h0);
    out_ready = 4'b0000;
  endtask

  task automatic test_async_reset();
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hA0A0A0A0;
    step();
    in_sel = 2'd3; in_data = 32'hB3B3B3B3;
    step();
    in_valid = 1'b0;
    chk("areset_pre_valid", {28'h0, out_valid}, 32'h9);
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", {28'h0, out_valid}, 32'h0);
    chk("areset_data0", out_data0, 32'h0);
    chk("areset_data3", out_data3, 32'h0);
    clear_sb();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 4'b1111;
    step();
    step();
    chk("areset_no_replay", {28'h0, out_valid}, 32'h0);
    out_ready = 4'b0000;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = $urandom();
      out_ready = 4'($urandom_range(0, 15));
      step();
    end
    in_valid = 1'b0;
    out_ready = 4'b1111;
    for (int c = 0; c < 20 && out_valid != 4'b0000; c++) step();
    chk("random_drained", {28'h0, out_valid}, 32'h0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("random_sb_empty_ch%0d", k), 32'(sb_q[k].size()), 32'h0);
    out_ready = 4'b0000;
  endtask

`ifdef DEMUX1_4_STATS_EN
  task automatic stream_to(input logic [1:0] ch, input int n);
    out_ready = 4'b0000;
    out_ready[ch] = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_sel = ch; in_data = 32'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    out_ready = 4'b0000;
  endtask

  task automatic test_stats();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("stats_cleared", stat_count[31:0] | stat_count[63:32], 32'h0);
    stream_to(2'd0, 5);
    stream_to(2'd3, 3);
    chk("stats_ch0", {16'h0, stat_count[15:0]}, 32'd5);
    chk("stats_ch3", {16'h0, stat_count[63:48]}, 32'd3);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h55;
    step();
    in_valid = 1'b0; out_ready = 4'b0001; stat_clr = 1'b1;
    step();
    stat_clr = 1'b0; out_ready = 4'b0000;
    chk("stats_clr_wins_lo", stat_count[31:0], 32'h0);
    chk("stats_clr_wins_hi", stat_count[63:32], 32'h0);
    stream_to(2'd1, 65536);
    chk("stats_wrap_ch1", {16'h0, stat_count[31:16]}, 32'h0);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_basic();
    test_stall();
    test_independence();
    test_stream();
    test_async_reset();
    test_random();
`ifdef DEMUX1_4_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
